// File: rtl/sw_max_score_tracker_pkg.sv
// Shared definitions for the Smith-Waterman max-score tracker.
package sw_max_score_tracker_pkg;

  // Default H-score width shared with the rest of the engine.
  localparam int V_E_F_BIT = 16;

  // The explicit values match the encodings used by existing software and debug tools.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sw_max_score_tracker_gt.sv
// Strict greater-than comparison of two sign-magnitude scores (MSB = sign).
module sw_sm_gt
  import sw_max_score_tracker_pkg::*;
#(
  parameter int DATA_WIDTH = V_E_F_BIT
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  gt
);

  localparam int MW = DATA_WIDTH - 1;

  logic          a_neg;
  logic          b_neg;
  logic [MW-1:0] a_mag;
  logic [MW-1:0] b_mag;

  assign a_neg = a[DATA_WIDTH-1];
  assign b_neg = b[DATA_WIDTH-1];
  assign a_mag = a[MW-1:0];
  assign b_mag = b[MW-1:0];

  // +0 counts as greater than -0, so the sign is decided before the magnitude is compared.
  always_comb begin
    gt = 1'b0;
    unique case ({a_neg, b_neg})
      2'b01:   gt = 1'b1;
      2'b10:   gt = 1'b0;
      2'b00:   gt = (a_mag > b_mag);
      default: gt = (a_mag < b_mag);
    endcase
  end

endmodule

// File: rtl/sw_max_score_tracker.sv
// Running-maximum tracker for one Smith-Waterman H-score matrix.
// Scores arrive row-fastest over a valid/ready handshake.
module sw_max_score_tracker
  import sw_max_score_tracker_pkg::*;
#(
  parameter int DATA_WIDTH = V_E_F_BIT,
  parameter int ROW_W      = 10,
  parameter int COL_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ROW_W-1:0]      i_rows,
  input  logic [COL_W-1:0]      i_cols,
  input  logic                  i_score_valid,
  input  logic [DATA_WIDTH-1:0] i_score,
  output logic                  o_score_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_max_score,
  output logic [ROW_W-1:0]      o_max_row,
  output logic [COL_W-1:0]      o_max_col,
  input  logic                  i_result_ack
);

  state_t                state;
  logic [ROW_W-1:0]      rows_q;
  logic [COL_W-1:0]      cols_q;
  logic [ROW_W-1:0]      row_cnt;
  logic [COL_W-1:0]      col_cnt;
  logic                  first_q;
  logic [DATA_WIDTH-1:0] max_q;
  logic [ROW_W-1:0]      max_row_q;
  logic [COL_W-1:0]      max_col_q;

  logic                  score_gt;
  logic [ROW_W-1:0]      row_last;
  logic [COL_W-1:0]      col_last;

  assign row_last = rows_q - ROW_W'(1);
  assign col_last = cols_q - COL_W'(1);

  sw_sm_gt #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_gt (
    .a  (i_score),
    .b  (max_q),
    .gt (score_gt)
  );

  // FSM, position counters and best-score registers. Counters return to zero after the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rows_q    <= '0;
      cols_q    <= '0;
      row_cnt   <= '0;
      col_cnt   <= '0;
      first_q   <= 1'b0;
      max_q     <= '0;
      max_row_q <= '0;
      max_col_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (i_start) begin
            rows_q    <= i_rows;
            cols_q    <= i_cols;
            row_cnt   <= '0;
            col_cnt   <= '0;
            first_q   <= 1'b1;
            max_q     <= '0;
            max_row_q <= '0;
            max_col_q <= '0;
            state     <= ((i_rows == '0) || (i_cols == '0)) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (i_score_valid) begin
            if (first_q || score_gt) begin
              max_q     <= i_score;
              max_row_q <= row_cnt;
              max_col_q <= col_cnt;
            end
            first_q <= 1'b0;
            if (row_cnt == row_last) begin
              row_cnt <= '0;
              if (col_cnt == col_last) begin
                col_cnt <= '0;
                state   <= ST_DONE;
              end else begin
                col_cnt <= col_cnt + COL_W'(1);
              end
            end else begin
              row_cnt <= row_cnt + ROW_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (i_result_ack) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_score_ready = (state == ST_RUN);
  assign o_busy        = (state == ST_RUN) || (state == ST_DONE);
  assign o_done        = (state == ST_DONE);
  assign o_max_score   = max_q;
  assign o_max_row     = max_row_q;
  assign o_max_col     = max_col_q;

endmodule

// File: tb/tb_sw_max_score_tracker.sv
// Directed bench for sw_max_score_tracker: table of matrices plus hand-written corner sequences.
module tb_sw_max_score_tracker;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [9:0]  i_rows;
  logic [15:0] i_cols;
  logic        i_score_valid;
  logic [15:0] i_score;
  logic        o_score_ready;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_max_score;
  logic [9:0]  o_max_row;
  logic [15:0] o_max_col;
  logic        i_result_ack;

  int n_tests = 0;
  int n_fail  = 0;

  sw_max_score_tracker #(
    .DATA_WIDTH (16),
    .ROW_W      (10),
    .COL_W      (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_rows        (i_rows),
    .i_cols        (i_cols),
    .i_score_valid (i_score_valid),
    .i_score       (i_score),
    .o_score_ready (o_score_ready),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_max_score   (o_max_score),
    .o_max_row     (o_max_row),
    .o_max_col     (o_max_col),
    .i_result_ack  (i_result_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  typedef struct packed {
    logic [9:0]  rows;
    logic [15:0] cols;
    int          off;
    logic [15:0] exp_max;
    logic [9:0]  exp_row;
    logic [15:0] exp_col;
    bit          rnd;
  } vec_t;

  vec_t        vecs [0:6];
  logic [15:0] pool [0:33];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, ".busy"},  32'(o_busy), 32'd0);
    chk({tag, ".done"},  32'(o_done), 32'd0);
    chk({tag, ".ready"}, 32'(o_score_ready), 32'd0);
    chk({tag, ".max"},   32'(o_max_score), 32'd0);
    chk({tag, ".row"},   32'(o_max_row), 32'd0);
    chk({tag, ".col"},   32'(o_max_col), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   n;
    int   idx;
    int   cyc;
    logic hs;
    logic early;
    n     = int'(v.rows) * int'(v.cols);
    idx   = 0;
    cyc   = 0;
    early = 1'b0;
    @(negedge clk);
    i_start = 1'b1;
    i_rows  = v.rows;
    i_cols  = v.cols;
    @(negedge clk);
    i_start = 1'b0;
    chk({tag, ".ready_run"}, 32'(o_score_ready), 32'd1);
    chk({tag, ".busy_run"},  32'(o_busy), 32'd1);
    while (idx < n && cyc < 400) begin
      i_score       = pool[v.off + idx];
      i_score_valid = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_done) early = 1'b1;
      hs = i_score_valid && o_score_ready;
      @(negedge clk);
      if (hs) idx++;
      cyc++;
    end
    i_score_valid = 1'b0;
    chk({tag, ".beats"},      32'(idx), 32'(n));
    chk({tag, ".early_done"}, 32'(early), 32'd0);
    chk({tag, ".done"},       32'(o_done), 32'd1);
    chk({tag, ".ready_done"}, 32'(o_score_ready), 32'd0);
    chk({tag, ".max"},        32'(o_max_score), 32'(v.exp_max));
    chk({tag, ".row"},        32'(o_max_row), 32'(v.exp_row));
    chk({tag, ".col"},        32'(o_max_col), 32'(v.exp_col));
    // Offer a larger score while DONE: it must not be taken.
    i_score       = 16'h7FFF;
    i_score_valid = 1'b1;
    repeat (2) @(negedge clk);
    i_score_valid = 1'b0;
    chk({tag, ".done_hold"}, 32'(o_done), 32'd1);
    chk({tag, ".max_hold"},  32'(o_max_score), 32'(v.exp_max));
    i_result_ack = 1'b1;
    @(negedge clk);
    i_result_ack = 1'b0;
    chk({tag, ".ack_done"}, 32'(o_done), 32'd0);
    chk({tag, ".ack_busy"}, 32'(o_busy), 32'd0);
    chk({tag, ".idle_max"}, 32'(o_max_score), 32'(v.exp_max));
    chk({tag, ".idle_col"}, 32'(o_max_col), 32'(v.exp_col));
  endtask

  initial begin
    pool = '{
      16'd5, 16'd9, 16'h8004, 16'd9, 16'd2, 16'd0,
      16'h8007, 16'h8003, 16'h8003, 16'h8008,
      16'h8000, 16'h0000,
      16'd3, 16'd7, 16'd7,
      16'd4, 16'h8014, 16'd17, 16'd3, 16'd8, 16'd17, 16'h8001, 16'd16, 16'd0, 16'd2, 16'h801E, 16'd9,
      16'h8064,
      16'h8000, 16'hFFFF, 16'h7FFF, 16'h7FFF, 16'd1, 16'd0
    };
    //            rows    cols    off  exp_max    row    col    rnd
    vecs[0] = '{10'd3, 16'd2, 0,  16'd9,     10'd1, 16'd0, 1'b0};
    vecs[1] = '{10'd2, 16'd2, 6,  16'h8003,  10'd1, 16'd0, 1'b0};
    vecs[2] = '{10'd2, 16'd1, 10, 16'h0000,  10'd1, 16'd0, 1'b0};
    vecs[3] = '{10'd1, 16'd3, 12, 16'd7,     10'd0, 16'd1, 1'b0};
    vecs[4] = '{10'd4, 16'd3, 15, 16'd17,    10'd2, 16'd0, 1'b1};
    vecs[5] = '{10'd1, 16'd1, 27, 16'h8064,  10'd0, 16'd0, 1'b0};
    vecs[6] = '{10'd2, 16'd3, 28, 16'h7FFF,  10'd0, 16'd1, 1'b1};

    rst           = 1'b1;
    i_start       = 1'b0;
    i_rows        = '0;
    i_cols        = '0;
    i_score_valid = 1'b0;
    i_score       = '0;
    i_result_ack  = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Empty matrix: straight to DONE with +0 at (0,0), previous result cleared.
    @(negedge clk);
    i_score_valid = 1'b1;
    i_score       = 16'd50;
    i_start       = 1'b1;
    i_rows        = 10'd0;
    i_cols        = 16'd5;
    @(negedge clk);
    i_start = 1'b0;
    chk("zero.done",  32'(o_done), 32'd1);
    chk("zero.ready", 32'(o_score_ready), 32'd0);
    chk("zero.max",   32'(o_max_score), 32'd0);
    chk("zero.row",   32'(o_max_row), 32'd0);
    chk("zero.col",   32'(o_max_col), 32'd0);
    @(negedge clk);
    chk("zero.ready2", 32'(o_score_ready), 32'd0);
    chk("zero.max2",   32'(o_max_score), 32'd0);
    i_score_valid = 1'b0;
    i_result_ack  = 1'b1;
    @(negedge clk);
    i_result_ack = 1'b0;
    chk("zero.ack_busy", 32'(o_busy), 32'd0);

    // Zero columns with nonzero rows also short-circuits.
    i_start = 1'b1;
    i_rows  = 10'd4;
    i_cols  = 16'd0;
    @(negedge clk);
    i_start = 1'b0;
    chk("zcol.done", 32'(o_done), 32'd1);
    i_result_ack = 1'b1;
    @(negedge clk);
    i_result_ack = 1'b0;

    // Reset mid-matrix after 3 of 6 beats.
    i_start = 1'b1;
    i_rows  = 10'd3;
    i_cols  = 16'd2;
    @(negedge clk);
    i_start       = 1'b0;
    i_score_valid = 1'b1;
    i_score       = 16'd33;
    repeat (3) @(negedge clk);
    i_score_valid = 1'b0;
    chk("mid.max_before_rst", 32'(o_max_score), 32'd33);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("rst_mid");
    run_vec(vecs[0], "after_rst");

    // i_start pulsed during RUN and together with the ack.
    @(negedge clk);
    i_start = 1'b1;
    i_rows  = 10'd2;
    i_cols  = 16'd2;
    @(negedge clk);
    i_start       = 1'b0;
    i_score_valid = 1'b1;
    i_score       = 16'd1;
    @(negedge clk);
    i_start = 1'b1;
    i_rows  = 10'd1;
    i_cols  = 16'd1;
    i_score = 16'd2;
    @(negedge clk);
    i_start = 1'b0;
    i_score = 16'd3;
    @(negedge clk);
    chk("restart.not_done_early", 32'(o_done), 32'd0);
    i_score = 16'd4;
    @(negedge clk);
    i_score_valid = 1'b0;
    chk("restart.done", 32'(o_done), 32'd1);
    chk("restart.max",  32'(o_max_score), 32'd4);
    chk("restart.row",  32'(o_max_row), 32'd1);
    chk("restart.col",  32'(o_max_col), 32'd1);
    i_start      = 1'b1;
    i_rows       = 10'd3;
    i_cols       = 16'd3;
    i_result_ack = 1'b1;
    @(negedge clk);
    i_start      = 1'b0;
    i_result_ack = 1'b0;
    chk("ackstart.busy", 32'(o_busy), 32'd0);
    chk("ackstart.done", 32'(o_done), 32'd0);
    @(negedge clk);
    chk("ackstart.busy2", 32'(o_busy), 32'd0);
    chk("ackstart.max",   32'(o_max_score), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
